// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder: FSM state encoding,
// port select values and default data/address widths.
package mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write, asynchronous read, no reset.
module mem_array #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder serving the instruction-fetch and data ports of the control
// FSM from one array, with WAIT_CYC wait states and a one-cycle ack per access.
module mem_responder #(
  parameter int DATA_W   = mem_pkg::DATA_W,
  parameter int ADDR_W   = mem_pkg::ADDR_W,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_ack,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state
);
  import mem_pkg::*;

  // Handshake: a request is a level held until its port's one-cycle ack; the
  // request is sampled only in IDLE, and everything it carries is latched then.
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              port_q, port_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              dm_req;
  logic              accept;
  logic              go_ack;
  logic              we;
  logic [DATA_W-1:0] rdata;

  assign dm_req = dm_rd | dm_wr;
  assign accept = (state_q == IDLE) && (dm_req || if_req);

  // The _d view of the transaction is the one completing at the next edge,
  // whether it was just accepted or latched earlier.
  always_comb begin
    port_d  = port_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      if (dm_req) begin
        port_d = PORT_DM;
        rd_d   = dm_rd;
        wr_d   = dm_wr;
        addr_d = dm_addr;
      end else begin
        port_d = PORT_IF;
        rd_d   = 1'b1;
        wr_d   = 1'b0;
        addr_d = if_addr;
      end
      wdata_d = dm_wdata;
    end
  end

  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(addr_d),
    .wdata(wdata_d),
    .raddr(addr_d),
    .rdata(rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    we         = 1'b0;
    go_ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d  = WAIT_LD;
          busy_d = 1'b1;
          if (WAIT_CYC == 0) begin
            state_d = ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ACK;
          go_ack  = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // Read data and the array write both land on the edge entering ACK.
    if (go_ack) begin
      if (port_d == PORT_IF) begin
        if_ack_d  = 1'b1;
        if_data_d = rdata;
      end else begin
        dm_ack_d = 1'b1;
        if (rd_d && wr_d) begin
          err_d = 1'b1;
        end else if (rd_d) begin
          dm_rdata_d = rdata;
        end else begin
          we = !rst;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      port_q     <= PORT_IF;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign if_data   = if_data_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle control FSM's memory strobes: the instruction fetch (IntMemRead) and data load/store (MemRead/MemWrite).
- Serves both request ports from one word-addressed storage array, with a configurable number of wait states.
- Returns a one-cycle ack per transaction, so the control FSM can stall in the IF and MEM states until the ack arrives.
- Fixed priority: data port over instruction port.

Parameters:
- DATA_W, 16, word width; matches the 16-bit ISA, 4-bit opcode/func.
- ADDR_W, 8, word address width; DEPTH = 2**ADDR_W words, so no address is out of range.
- WAIT_CYC, 2, wait states between request acceptance and ack; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- if_req  in  1  instruction read request; level, held until if_ack.
- if_addr  in  ADDR_W  instruction address; stable while if_req is high.
- if_data  out  DATA_W  instruction word; registered.
- if_ack  out  1  one-cycle completion pulse for the instruction port.
- dm_rd  in  1  data read request; level, held until dm_ack.
- dm_wr  in  1  data write request; level, held until dm_ack.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  load data; registered.
- dm_ack  out  1  one-cycle completion pulse for the data port.
- busy  out  1  high while a transaction is in flight.
- err  out  1  one-cycle pulse for an illegal data request.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: if_ack=0, dm_ack=0, if_data=0, dm_rdata=0, busy=0, err=0, state=IDLE, counter=0. The storage array is not cleared.
- States: IDLE, WAIT, ACK.
- IDLE, at a clk edge with any request high:
  - Select the data port if dm_rd|dm_wr, otherwise the instruction port.
  - Latch port, op, addr and wdata; load counter=WAIT_CYC.
  - Go to WAIT if WAIT_CYC>0, otherwise go to ACK.
- IDLE with no request: stay in IDLE.
- WAIT: decrement the counter each cycle; when the counter reaches 1, go to ACK. Exactly WAIT_CYC cycles are spent in WAIT.
- ACK: lasts one cycle, then returns to IDLE unconditionally.
  - The selected port's ack is high for this cycle only.
  - For a read, the port's data output updates on entry to ACK.
  - For a write, the array is written at the edge entering ACK.
- Latency: for a request accepted at edge t, ack is high in cycle t+WAIT_CYC+1. Total is WAIT_CYC+2 cycles from acceptance to the next acceptance.
- Read data holds its value until the next read ack on the same port. if_data and dm_rdata are independent registers.
- Requester obligations:
  - Keep addr and wdata stable until ack.
  - Drop the request in the ack cycle; a request still high at the edge leaving ACK is accepted as a new transaction.
- Inputs are latched at acceptance, so changes during WAIT are ignored.
- busy=1 in WAIT and ACK.
- Priority: if if_req and dm_* are high in the same IDLE cycle, the data port is served first. The instruction request is accepted at the IDLE edge after the data ACK, provided it is still held. A pending if_req is never lost, only delayed.
- dm_rd and dm_wr both high at acceptance:
  - Treated as illegal; no array write.
  - dm_rdata is unchanged.
  - err pulses in the ACK cycle and dm_ack is still returned, so the requester cannot hang.
- Reset mid-transaction: an in-flight write is dropped, no ack is issued, and the state returns to IDLE.
- Read-after-write to the same address returns the new data.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE=2'b00, WAIT=2'b01, ACK=2'b10);
  - port select constants (PORT_IF=0, PORT_DM=1);
  - default widths DATA_W=16 and ADDR_W=8.
- One sub-module, mem_array: DEPTH x DATA_W storage, synchronous write (we, waddr, wdata), asynchronous read (raddr → rdata), no reset.
- mem_responder holds the FSM, wait counter, request latch, priority select and output registers.

Test Plan:
- Reset held for 2 cycles with dm_wr=1 → all outputs 0, no ack, and after release mem[addr] is unchanged.
- WAIT_CYC=2: dm_wr addr=8'h10 data=16'hA5C3 accepted at edge t → dm_ack high only in cycle t+3. Then dm_rd addr=8'h10 → dm_rdata=16'hA5C3 with dm_ack, and busy=1 for 3 cycles per transaction.
- if_req addr=8'h04 and dm_rd addr=8'h20 raised in the same cycle → dm_ack first with mem[8'h20]; if_ack is high exactly WAIT_CYC+2 cycles after the dm_ack cycle, with if_data=mem[8'h04].
- WAIT_CYC=0: back-to-back if_req held continuously, addresses 0,1,2 → if_ack every 2nd cycle, with if_data sequence mem[0], mem[1], mem[2].
- dm_rd=dm_wr=1 at addr 8'h30 (preloaded 16'h1234) → err and dm_ack pulse together, mem[8'h30] stays 16'h1234, dm_rdata unchanged.
- Assert rst during WAIT of a write of 16'hFFFF to 8'h40 (preloaded 16'h0001) → no dm_ack, state IDLE, a subsequent read returns 16'h0001.
